mode_seq_counter: RTL and testbench

Parametrised multi-mode sequence counter: the next generation of the team's 2-bit fixed-sequence flip-flop state machines. Holds a WIDTH-bit state register and steps it on every enabled clock through one of four runtime-selectable sequences (binary up, binary down, Gray up, Johnson), with a programmable wrap limit, synchronous load and terminal-count/wrap flags. Used as a generic sequencer or pattern source for lab-level designs and as a timebase for downstream FSMs.

---
 rtl/mode_seq_counter.sv | 88 ++++++++
 tb/tb_mode_seq_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_seq_counter.sv
// Multi-mode sequence counter: UP, DOWN, GRAY and JOHNSON sequences
// with a live wrap limit, synchronous load and tc/wrap flags.
module mode_seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             t_clock,
   input  logic             t_reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   typedef enum logic [1:0] {
      M_UP   = 2'd0,
      M_DOWN = 2'd1,
      M_GRAY = 2'd2,
      M_JOHN = 2'd3
   } mode_e;

   localparam logic [WIDTH-1:0] JTOP = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_e            mode_q, mode_d, mode_in;
   logic [WIDTH-1:0] st_q, st_d;
   logic             wrap_q, wrap_d;

   assign mode_in = mode_e'(mode);

   always_ff @(posedge t_clock or posedge t_reset) begin
      if (t_reset) begin
         st_q   <= '0;
         mode_q <= M_UP;
         wrap_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      st_d   = st_q;
      wrap_d = 1'b0;
      if (mode_in != mode_q) begin
         // A mode switch restarts the sequence at its natural origin
         mode_d = mode_in;
         st_d   = (mode_in == M_DOWN) ? limit : '0;
      end else if (load) begin
         st_d = load_val;
      end else if (en) begin
         unique case (mode_q)
            M_UP, M_GRAY: begin
               wrap_d = (st_q >= limit);
               st_d   = wrap_d ? '0 : st_q + ONE;
            end
            M_DOWN: begin
               wrap_d = (st_q == '0);
               st_d   = wrap_d ? limit : st_q - ONE;
            end
            M_JOHN: begin
               wrap_d = (st_q == JTOP);
               st_d   = {st_q[WIDTH-2:0], ~st_q[WIDTH-1]};
            end
            default: st_d = st_q;
         endcase
      end
   end

   always_comb begin
      tc = 1'b0;
      unique case (mode_q)
         M_UP, M_GRAY: tc = (st_q == limit);
         M_DOWN:       tc = (st_q == '0);
         M_JOHN:       tc = (st_q == JTOP);
         default:      tc = 1'b0;
      endcase
   end

   assign q    = (mode_q == M_GRAY) ? (st_q ^ (st_q >> 1)) : st_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_mode_seq_counter.sv
// Directed self-checking bench for mode_seq_counter, WIDTH=4.
module tb_mode_seq_counter;

   logic       t_clock;
   logic       t_reset;
   logic       en;
   logic [1:0] mode;
   logic [3:0] limit;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc;
   logic       wrap;

   int checks;
   int failures;

   int up_q[7]    = '{1, 2, 3, 4, 5, 0, 1};
   int gray_q[8]  = '{1, 3, 2, 6, 7, 5, 4, 0};
   int john_q[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};

   mode_seq_counter #(.WIDTH(4)) dut (
      .t_clock (t_clock),
      .t_reset (t_reset),
      .en      (en),
      .mode    (mode),
      .limit   (limit),
      .load    (load),
      .load_val(load_val),
      .q       (q),
      .tc      (tc),
      .wrap    (wrap)
   );

   initial t_clock = 1'b0;
   always #5 t_clock = ~t_clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge t_clock);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      t_reset  = 1'b1;
      en       = 1'b0;
      mode     = 2'd0;
      limit    = 4'd5;
      load     = 1'b0;
      load_val = 4'd0;
      #3;
      check("rst_q", q, 0);
      check("rst_wrap", wrap, 0);
      check("rst_tc", tc, 0);
      step();
      t_reset = 1'b0;

      // UP, limit 5
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check("up_q", q, up_q[i]);
         check("up_tc", tc, (up_q[i] == 5) ? 1 : 0);
         check("up_wrap", wrap, (i == 5) ? 1 : 0);
      end
      en = 1'b0;
      step();
      step();
      check("hold_q", q, 1);
      check("hold_wrap", wrap, 0);

      // async reset mid-count at q=3
      en = 1'b1;
      step();
      step();
      check("pre_rst_q", q, 3);
      t_reset = 1'b1;
      #2;
      check("arst_q", q, 0);
      check("arst_wrap", wrap, 0);
      check("arst_tc", tc, 0);
      t_reset = 1'b0;
      step();
      check("resume1", q, 1);
      step();
      check("resume2", q, 2);

      // reset beats load
      load     = 1'b1;
      load_val = 4'd9;
      t_reset  = 1'b1;
      step();
      check("rst_load_q", q, 0);
      t_reset = 1'b0;
      load    = 1'b0;

      // DOWN, limit 3, then limit raised live
      mode  = 2'd1;
      limit = 4'd3;
      step();
      check("dn_start", q, 3);
      check("dn_start_tc", tc, 0);
      step();
      check("dn_2", q, 2);
      step();
      check("dn_1", q, 1);
      step();
      check("dn_0", q, 0);
      check("dn_tc", tc, 1);
      step();
      check("dn_wrapq", q, 3);
      check("dn_wrap", wrap, 1);
      step();
      check("dn_2b", q, 2);
      check("dn_nowrap", wrap, 0);
      limit = 4'd9;
      step();
      check("dn_1b", q, 1);
      step();
      check("dn_0b", q, 0);
      step();
      check("dn_9", q, 9);
      check("dn_wrap9", wrap, 1);

      // GRAY, limit 7
      mode  = 2'd2;
      limit = 4'd7;
      step();
      check("gr_start", q, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("gr_q", q, gray_q[i]);
         check("gr_tc", tc, (i == 6) ? 1 : 0);
         check("gr_wrap", wrap, (i == 7) ? 1 : 0);
      end
      // load beats en; out-of-range state wraps next step
      load     = 1'b1;
      load_val = 4'd12;
      step();
      check("gr_load_q", q, 10);
      check("gr_load_tc", tc, 0);
      load = 1'b0;
      step();
      check("gr_oor_q", q, 0);
      check("gr_oor_wrap", wrap, 1);

      // JOHNSON
      mode = 2'd3;
      step();
      check("jn_start", q, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("jn_q", q, john_q[i]);
         check("jn_tc", tc, (i == 6) ? 1 : 0);
         check("jn_wrap", wrap, (i == 7) ? 1 : 0);
      end
      load     = 1'b1;
      load_val = 4'd5;
      step();
      check("jn_load", q, 5);
      load = 1'b0;
      step();
      check("jn_shift", q, 11);

      // mode change beats load
      mode     = 2'd0;
      load     = 1'b1;
      load_val = 4'd9;
      step();
      check("mc_load_q", q, 0);
      load_val = 4'd4;
      step();
      check("up_load_q", q, 4);
      load = 1'b0;
      step();
      check("up_after_load", q, 5);

      // limit 0 in UP
      limit = 4'd0;
      mode  = 2'd0;
      #1;
      check("lim0_tc_pre", tc, 0);
      step();
      check("lim0_oor_q", q, 0);
      check("lim0_tc", tc, 1);
      step();
      check("lim0_hold_q", q, 0);
      check("lim0_wrap", wrap, 1);

      // held DOWN mode across reset reloads on first edge
      mode    = 2'd1;
      limit   = 4'd6;
      t_reset = 1'b1;
      #2;
      check("rst_dn_q", q, 0);
      check("rst_dn_tc", tc, 0);
      step();
      t_reset = 1'b0;
      step();
      check("rst_dn_reload", q, 6);
      step();
      check("rst_dn_step", q, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
